// File: rtl/add_round_key_ser.sv
// Byte-serial AES-128 AddRoundKey: buffers 16 key and 16 state bytes, streams key^state.
// Define ARK_KEY_FWD_EN to re-stream the round key on key_fwd/key_fwd_en after each block.
module add_round_key_ser #(
    parameter int NB = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] key_in,
    input  logic          key_en,
    input  logic [DW-1:0] state_in,
    input  logic          state_en,
    output logic [DW-1:0] dout,
    output logic          enable_out,
    output logic          round_complete,
    output logic          busy
`ifdef ARK_KEY_FWD_EN
    ,
    output logic [DW-1:0] key_fwd,
    output logic          key_fwd_en
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        XOR,
        DONE
`ifdef ARK_KEY_FWD_EN
        ,
        FWD
`endif
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] kbuf [NB];
    logic [DW-1:0] sbuf [NB];
    logic [4:0] kc, sc, oc;
    logic [4:0] kc_nxt, sc_nxt;
    logic key_take, st_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        key_take  = 1'b0;
        st_take   = 1'b0;
        kc_nxt    = kc;
        sc_nxt    = sc;
        case (state)
            IDLE, LOAD: begin
                // A full stream (ptr==16) stops accepting; the other keeps filling.
                key_take = key_en && !kc[4];
                st_take  = state_en && !sc[4];
                kc_nxt   = kc + {4'd0, key_take};
                sc_nxt   = sc + {4'd0, st_take};
                if (kc_nxt[4] && sc_nxt[4])
                    state_nxt = XOR;
                else if (key_take || st_take)
                    state_nxt = LOAD;
            end
            XOR: begin
                if (oc == 5'd15) state_nxt = DONE;
            end
            DONE: begin
`ifdef ARK_KEY_FWD_EN
                if (round_complete) state_nxt = FWD;
`else
                if (round_complete) state_nxt = IDLE;
`endif
            end
`ifdef ARK_KEY_FWD_EN
            FWD: begin
                if (oc[4] && !key_fwd_en) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == XOR) || (state == DONE);
`ifdef ARK_KEY_FWD_EN
        if (state == FWD) busy = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (key_take) kbuf[kc[3:0]] <= key_in;
        if (st_take)  sbuf[sc[3:0]] <= state_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kc             <= '0;
            sc             <= '0;
            oc             <= '0;
            dout           <= '0;
            enable_out     <= 1'b0;
            round_complete <= 1'b0;
`ifdef ARK_KEY_FWD_EN
            key_fwd        <= '0;
            key_fwd_en     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, LOAD: begin
                    kc <= kc_nxt;
                    sc <= sc_nxt;
                end
                XOR: begin
                    dout       <= kbuf[oc[3:0]] ^ sbuf[oc[3:0]];
                    enable_out <= 1'b1;
                    oc         <= oc + 5'd1;
                end
                DONE: begin
                    // Two edges here: raise the pulse, then drop it and rearm.
                    enable_out <= 1'b0;
                    if (!round_complete) begin
                        round_complete <= 1'b1;
                    end else begin
                        round_complete <= 1'b0;
                        kc             <= '0;
                        sc             <= '0;
                        oc             <= '0;
                    end
                end
`ifdef ARK_KEY_FWD_EN
                FWD: begin
                    if (!oc[4]) begin
                        key_fwd    <= kbuf[oc[3:0]];
                        key_fwd_en <= 1'b1;
                        oc         <= oc + 5'd1;
                    end else if (key_fwd_en) begin
                        key_fwd_en <= 1'b0;
                    end else begin
                        oc <= '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_round_key_ser.sv
// Directed bench for add_round_key_ser using FIPS-197 Appendix B / C.1 round-0 vectors.
// Build with ARK_KEY_FWD_EN defined to also check the key forwarding stream.
module tb_add_round_key_ser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_in = '0;
    logic       key_en = 1'b0;
    logic [7:0] state_in = '0;
    logic       state_en = 1'b0;
    logic [7:0] dout;
    logic       enable_out;
    logic       round_complete;
    logic       busy;
`ifdef ARK_KEY_FWD_EN
    logic [7:0] key_fwd;
    logic       key_fwd_en;
`endif

    int checks = 0;
    int errors = 0;

    add_round_key_ser dut (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key_in),
        .key_en         (key_en),
        .state_in       (state_in),
        .state_en       (state_en),
        .dout           (dout),
        .enable_out     (enable_out),
        .round_complete (round_complete),
        .busy           (busy)
`ifdef ARK_KEY_FWD_EN
        ,
        .key_fwd        (key_fwd),
        .key_fwd_en     (key_fwd_en)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return v[127 - 8*i -: 8];
    endfunction

    // mode 0 interleaved, 1 keys/gap/states, 2 parallel, 3 20 keys then states
    task automatic send_block(input logic [127:0] k, input logic [127:0] s,
                              input int mode);
        case (mode)
            0: for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                key_en = 1'b1; key_in = byte_of(k, i); state_en = 1'b0;
                @(negedge clk);
                key_en = 1'b0; state_en = 1'b1; state_in = byte_of(s, i);
            end
            2: for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                key_en = 1'b1; key_in = byte_of(k, i);
                state_en = 1'b1; state_in = byte_of(s, i);
            end
            default: begin
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    key_en = 1'b1; key_in = byte_of(k, i);
                end
                if (mode == 3)
                    for (int i = 0; i < 4; i++) begin
                        @(negedge clk);
                        key_en = 1'b1; key_in = 8'hA0 + 8'(i);
                    end
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    key_en = 1'b0;
                end
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    state_en = 1'b1; state_in = byte_of(s, i);
                end
            end
        endcase
    endtask

    task automatic expect_block(input logic [127:0] k, input logic [127:0] exp,
                                input bit junk, input int abort_at);
        @(negedge clk);
        key_en = 1'b0; state_en = 1'b0;
        check("busy_after_last", 32'(busy), 1);
        check("en_after_last", 32'(enable_out), 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("en_b%0d", i), 32'(enable_out), 1);
            check($sformatf("dout_b%0d", i), 32'(dout), 32'(byte_of(exp, i)));
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_dout", 32'(dout), 0);
                check("rst_en", 32'(enable_out), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_rc", 32'(round_complete), 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            key_en = junk; key_in = 8'h5A;
            state_en = junk; state_in = 8'hC3;
        end
        key_en = 1'b0; state_en = 1'b0;
        @(negedge clk);
        check("done_en", 32'(enable_out), 0);
        check("done_rc", 32'(round_complete), 1);
        check("done_dout_hold", 32'(dout), 32'(byte_of(exp, 15)));
        @(negedge clk);
        check("rc_drop", 32'(round_complete), 0);
`ifdef ARK_KEY_FWD_EN
        check("fwd_busy0", 32'(busy), 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("fwd_en%0d", i), 32'(key_fwd_en), 1);
            check($sformatf("fwd_b%0d", i), 32'(key_fwd), 32'(byte_of(k, i)));
            check($sformatf("fwd_busy%0d", i), 32'(busy), 1);
        end
        @(negedge clk);
        check("fwd_en_fall", 32'(key_fwd_en), 0);
        check("fwd_busy_hold", 32'(busy), 1);
        @(negedge clk);
        check("fwd_busy_fall", 32'(busy), 0);
`else
        check("busy_idle", 32'(busy), 0);
        check("key_unused", 32'(k[7:0]), 32'(k[7:0]) );
`endif
    endtask

    logic [127:0] k_c1, s_c1, o_c1, k_b, s_b, o_b;

    initial begin
        k_c1 = 128'h000102030405060708090a0b0c0d0e0f;
        s_c1 = 128'h00112233445566778899aabbccddeeff;
        o_c1 = 128'h00102030405060708090a0b0c0d0e0f0;
        k_b  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        s_b  = 128'h3243f6a8885a308d313198a2e0370734;
        o_b  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

        repeat (3) @(negedge clk);
        check("reset_dout", 32'(dout), 0);
        check("reset_en", 32'(enable_out), 0);
        check("reset_rc", 32'(round_complete), 0);
        check("reset_busy", 32'(busy), 0);
`ifdef ARK_KEY_FWD_EN
        check("reset_fwd", 32'(key_fwd), 0);
        check("reset_fwd_en", 32'(key_fwd_en), 0);
`endif
        rst = 1'b0;

        send_block(k_c1, s_c1, 0);
        expect_block(k_c1, o_c1, 1'b0, -1);

        send_block(k_c1, s_c1, 1);
        expect_block(k_c1, o_c1, 1'b0, -1);

        send_block(k_b, s_b, 2);
        expect_block(k_b, o_b, 1'b0, -1);

        send_block(k_c1, s_c1, 3);
        expect_block(k_c1, o_c1, 1'b1, -1);
        send_block(k_b, s_b, 2);
        expect_block(k_b, o_b, 1'b0, -1);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            key_en = 1'b1; key_in = 8'hEE;
        end
        @(negedge clk);
        key_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_load_busy", 32'(busy), 0);
        check("rst_load_en", 32'(enable_out), 0);
        @(negedge clk);
        rst = 1'b0;
        send_block(k_c1, s_c1, 0);
        expect_block(k_c1, o_c1, 1'b0, 7);
        send_block(k_b, s_b, 0);
        expect_block(k_b, o_b, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
